// File: rtl/clock_pkg.sv
// Shared mode encodings and field limits for the clock time controller.
// Imported by the controller and its testbench.
package clock_pkg;

    typedef enum logic [1:0] {
        MODE_RUN      = 2'd0,
        MODE_SET_HOUR = 2'd1,
        MODE_SET_MIN  = 2'd2,
        MODE_SET_SEC  = 2'd3
    } mode_e;

    localparam int HOUR_MAX = 23;
    localparam int MIN_MAX  = 59;
    localparam int SEC_MAX  = 59;

endpackage

// File: rtl/wrap_counter.sv
// Modulo (MAX+1) counter with synchronous clear and a combinational
// carry that fires on the increment that wraps MAX back to zero.
module wrap_counter #(
    parameter int WIDTH = 6,
    parameter int MAX   = 59
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] value,
    output logic             carry
);

    localparam logic [WIDTH-1:0] L_MAX = WIDTH'(MAX);

    logic [WIDTH-1:0] r_value;

    assign value = r_value;
    assign carry = inc && (r_value == L_MAX);

    // Count up with wrap at MAX; clear takes priority over increment
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_value <= '0;
        end else if (inc) begin
            r_value <= (r_value == L_MAX) ? '0 : r_value + 1'b1;
        end
    end

endmodule

// File: rtl/clock_time_controller.sv
// hh:mm:ss time keeper with a RUN/SET mode FSM, set-mode blink
// and an idle timeout that drops back to RUN.
module clock_time_controller
    import clock_pkg::*;
#(
    parameter int TIMEOUT_S = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [4:0] hour,
    output logic [5:0] min,
    output logic [5:0] sec,
    output logic [1:0] mode,
    output logic       blink
);

    localparam logic [5:0] L_IDLE_LAST = 6'(TIMEOUT_S - 1);

    mode_e      r_state;
    mode_e      w_state_nxt;
    logic       r_blink;
    logic       w_blink_nxt;
    logic [5:0] r_idle;
    logic [5:0] w_idle_nxt;

    logic w_run;
    logic w_inc_btn;
    logic w_sec_inc;
    logic w_sec_clr;
    logic w_min_inc;
    logic w_hour_inc;
    logic w_sec_carry;
    logic w_min_carry;
    logic w_unused_hour_carry;

    // btn_mode wins over btn_inc in the same cycle
    assign w_inc_btn = btn_inc && !btn_mode;
    assign w_run     = (r_state == MODE_RUN);

    // Carries chain only while running; SET modes touch one field each
    assign w_sec_inc  = w_run && tick_1hz;
    assign w_sec_clr  = (r_state == MODE_SET_SEC) && w_inc_btn;
    assign w_min_inc  = w_run ? w_sec_carry
                              : (r_state == MODE_SET_MIN) && w_inc_btn;
    assign w_hour_inc = w_run ? w_min_carry
                              : (r_state == MODE_SET_HOUR) && w_inc_btn;

    wrap_counter #(.WIDTH(6), .MAX(SEC_MAX)) u_sec (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_sec_inc),
        .clr   (w_sec_clr),
        .value (sec),
        .carry (w_sec_carry)
    );

    wrap_counter #(.WIDTH(6), .MAX(MIN_MAX)) u_min (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_min_inc),
        .clr   (1'b0),
        .value (min),
        .carry (w_min_carry)
    );

    wrap_counter #(.WIDTH(5), .MAX(HOUR_MAX)) u_hour (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_hour_inc),
        .clr   (1'b0),
        .value (hour),
        .carry (w_unused_hour_carry)
    );

    // Mode, blink and idle-counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= MODE_RUN;
            r_blink <= 1'b0;
            r_idle  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_blink <= w_blink_nxt;
            r_idle  <= w_idle_nxt;
        end
    end

    // Next mode, blink phase and idle count from buttons and ticks
    always_comb begin
        w_state_nxt = r_state;
        w_blink_nxt = r_blink;
        w_idle_nxt  = r_idle;
        if (btn_mode) begin
            w_idle_nxt = '0;
            unique case (r_state)
                MODE_RUN:      w_state_nxt = MODE_SET_HOUR;
                MODE_SET_HOUR: w_state_nxt = MODE_SET_MIN;
                MODE_SET_MIN:  w_state_nxt = MODE_SET_SEC;
                MODE_SET_SEC:  w_state_nxt = MODE_RUN;
                default:       w_state_nxt = MODE_RUN;
            endcase
            w_blink_nxt = (w_state_nxt != MODE_RUN);
        end else if (w_run) begin
            w_blink_nxt = 1'b0;
            w_idle_nxt  = '0;
        end else if (btn_inc) begin
            w_idle_nxt = '0;
        end else if (tick_1hz) begin
            if (r_idle == L_IDLE_LAST) begin
                w_state_nxt = MODE_RUN;
                w_blink_nxt = 1'b0;
                w_idle_nxt  = '0;
            end else begin
                w_idle_nxt  = r_idle + 6'd1;
                w_blink_nxt = !r_blink;
            end
        end
    end

    assign mode  = r_state;
    assign blink = r_blink;

endmodule

// File: tb/tb_clock_time_controller.sv
// Scenario testbench for clock_time_controller.
// Each step queues its expected outputs, drives, then pops and compares.
module tb_clock_time_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
    logic [1:0] mode;
    logic       blink;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string nm;
        int    n;
        bit    r;
        bit    t;
        bit    bm;
        bit    bi;
        int    h;
        int    mi;
        int    s;
        int    md;
        int    b;
    } vec_t;

    vec_t sb[$];
    vec_t e;

    always #5 clk = ~clk;

    clock_time_controller #(.TIMEOUT_S(30)) dut (
        .clk      (clk),
        .rst      (rst),
        .tick_1hz (tick_1hz),
        .btn_mode (btn_mode),
        .btn_inc  (btn_inc),
        .hour     (hour),
        .min      (min),
        .sec      (sec),
        .mode     (mode),
        .blink    (blink)
    );

    function automatic vec_t mk(string nm, int n, bit r, bit t, bit bm,
                                bit bi, int h, int mi, int s, int md, int b);
        vec_t v;
        v.nm = nm; v.n = n; v.r = r; v.t = t; v.bm = bm; v.bi = bi;
        v.h = h; v.mi = mi; v.s = s; v.md = md; v.b = b;
        return v;
    endfunction

    // One clock of stimulus; outputs are settled 1ns after the edge
    task automatic drv(input bit r, input bit t, input bit bm, input bit bi);
        @(negedge clk);
        rst = r; tick_1hz = t; btn_mode = bm; btn_inc = bi;
        @(posedge clk);
        #1;
        rst = 1'b0; tick_1hz = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
    endtask

    task automatic test_reset();
        vec_t v[$];
        v.push_back(mk("reset", 2, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        v.push_back(mk("reset_over_inputs", 1, 1, 1, 1, 1, 0, 0, 0, 0, 0));
        for (int k = 0; k < v.size(); k++) begin
            sb.push_back(v[k]);
            repeat (v[k].n) drv(v[k].r, v[k].t, v[k].bm, v[k].bi);
            e = sb.pop_front();
            tests++;
            if ({hour, min, sec, mode, blink} !==
                {5'(e.h), 6'(e.mi), 6'(e.s), 2'(e.md), 1'(e.b)}) begin
                fails++;
                $display("FAIL %s: got %0d:%0d:%0d mode=%0d blink=%0d, want %0d:%0d:%0d mode=%0d blink=%0d",
                         e.nm, hour, min, sec, mode, blink, e.h, e.mi, e.s, e.md, e.b);
            end
        end
    endtask

    task automatic test_run_count();
        vec_t v[$];
        v.push_back(mk("run_rst", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        v.push_back(mk("run_59", 59, 0, 1, 0, 0, 0, 0, 59, 0, 0));
        v.push_back(mk("run_60", 1, 0, 1, 0, 0, 0, 1, 0, 0, 0));
        v.push_back(mk("run_61", 1, 0, 1, 0, 0, 0, 1, 1, 0, 0));
        v.push_back(mk("run_inc_ignored", 3, 0, 0, 0, 1, 0, 1, 1, 0, 0));
        for (int k = 0; k < v.size(); k++) begin
            sb.push_back(v[k]);
            repeat (v[k].n) drv(v[k].r, v[k].t, v[k].bm, v[k].bi);
            e = sb.pop_front();
            tests++;
            if ({hour, min, sec, mode, blink} !==
                {5'(e.h), 6'(e.mi), 6'(e.s), 2'(e.md), 1'(e.b)}) begin
                fails++;
                $display("FAIL %s: got %0d:%0d:%0d mode=%0d blink=%0d, want %0d:%0d:%0d mode=%0d blink=%0d",
                         e.nm, hour, min, sec, mode, blink, e.h, e.mi, e.s, e.md, e.b);
            end
        end
    endtask

    task automatic test_day_wrap();
        vec_t v[$];
        v.push_back(mk("dw_rst", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        v.push_back(mk("dw_set_hour", 1, 0, 0, 1, 0, 0, 0, 0, 1, 1));
        v.push_back(mk("dw_hour23", 23, 0, 0, 0, 1, 23, 0, 0, 1, 1));
        v.push_back(mk("dw_set_min", 1, 0, 0, 1, 0, 23, 0, 0, 2, 1));
        v.push_back(mk("dw_min59", 59, 0, 0, 0, 1, 23, 59, 0, 2, 1));
        v.push_back(mk("dw_set_sec", 1, 0, 0, 1, 0, 23, 59, 0, 3, 1));
        v.push_back(mk("dw_sec_clr", 1, 0, 0, 0, 1, 23, 59, 0, 3, 1));
        v.push_back(mk("dw_run", 1, 0, 0, 1, 0, 23, 59, 0, 0, 0));
        v.push_back(mk("dw_235959", 59, 0, 1, 0, 0, 23, 59, 59, 0, 0));
        v.push_back(mk("dw_midnight", 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        v.push_back(mk("dw_after", 1, 0, 1, 0, 0, 0, 0, 1, 0, 0));
        for (int k = 0; k < v.size(); k++) begin
            sb.push_back(v[k]);
            repeat (v[k].n) drv(v[k].r, v[k].t, v[k].bm, v[k].bi);
            e = sb.pop_front();
            tests++;
            if ({hour, min, sec, mode, blink} !==
                {5'(e.h), 6'(e.mi), 6'(e.s), 2'(e.md), 1'(e.b)}) begin
                fails++;
                $display("FAIL %s: got %0d:%0d:%0d mode=%0d blink=%0d, want %0d:%0d:%0d mode=%0d blink=%0d",
                         e.nm, hour, min, sec, mode, blink, e.h, e.mi, e.s, e.md, e.b);
            end
        end
    endtask

    task automatic test_set_wrap();
        vec_t v[$];
        v.push_back(mk("sw_rst", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        v.push_back(mk("sw_pre", 5, 0, 1, 0, 0, 0, 0, 5, 0, 0));
        v.push_back(mk("sw_set_hour", 1, 0, 0, 1, 0, 0, 0, 5, 1, 1));
        v.push_back(mk("sw_hour23", 23, 0, 0, 0, 1, 23, 0, 5, 1, 1));
        v.push_back(mk("sw_hour_wrap", 1, 0, 0, 0, 1, 0, 0, 5, 1, 1));
        v.push_back(mk("sw_set_min", 1, 0, 0, 1, 0, 0, 0, 5, 2, 1));
        v.push_back(mk("sw_min59", 59, 0, 0, 0, 1, 0, 59, 5, 2, 1));
        v.push_back(mk("sw_min_wrap", 1, 0, 0, 0, 1, 0, 0, 5, 2, 1));
        v.push_back(mk("sw_set_sec", 1, 0, 0, 1, 0, 0, 0, 5, 3, 1));
        v.push_back(mk("sw_sec_clr", 1, 0, 0, 0, 1, 0, 0, 0, 3, 1));
        v.push_back(mk("sw_sec_frozen", 3, 0, 1, 0, 0, 0, 0, 0, 3, 0));
        v.push_back(mk("sw_run", 1, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < v.size(); k++) begin
            sb.push_back(v[k]);
            repeat (v[k].n) drv(v[k].r, v[k].t, v[k].bm, v[k].bi);
            e = sb.pop_front();
            tests++;
            if ({hour, min, sec, mode, blink} !==
                {5'(e.h), 6'(e.mi), 6'(e.s), 2'(e.md), 1'(e.b)}) begin
                fails++;
                $display("FAIL %s: got %0d:%0d:%0d mode=%0d blink=%0d, want %0d:%0d:%0d mode=%0d blink=%0d",
                         e.nm, hour, min, sec, mode, blink, e.h, e.mi, e.s, e.md, e.b);
            end
        end
    endtask

    task automatic test_blink_timeout();
        vec_t v[$];
        v.push_back(mk("bt_rst", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        v.push_back(mk("bt_enter", 1, 0, 0, 1, 0, 0, 0, 0, 1, 1));
        for (int k = 1; k <= 5; k++)
            v.push_back(mk("bt_blink", 1, 0, 1, 0, 0, 0, 0, 0, 1, (k % 2 == 1) ? 0 : 1));
        v.push_back(mk("bt_tick29", 24, 0, 1, 0, 0, 0, 0, 0, 1, 0));
        v.push_back(mk("bt_timeout", 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        v.push_back(mk("bt_run_after", 1, 0, 1, 0, 0, 0, 0, 1, 0, 0));
        v.push_back(mk("bt_enter2", 1, 0, 0, 1, 0, 0, 0, 1, 1, 1));
        v.push_back(mk("bt_idle20", 20, 0, 1, 0, 0, 0, 0, 1, 1, 1));
        v.push_back(mk("bt_inc_clears", 1, 0, 0, 0, 1, 1, 0, 1, 1, 1));
        v.push_back(mk("bt_idle29", 29, 0, 1, 0, 0, 1, 0, 1, 1, 0));
        v.push_back(mk("bt_btn_beats_to", 1, 0, 1, 0, 1, 2, 0, 1, 1, 0));
        v.push_back(mk("bt_idle29b", 29, 0, 1, 0, 0, 2, 0, 1, 1, 1));
        v.push_back(mk("bt_timeout2", 1, 0, 1, 0, 0, 2, 0, 1, 0, 0));
        for (int k = 0; k < v.size(); k++) begin
            sb.push_back(v[k]);
            repeat (v[k].n) drv(v[k].r, v[k].t, v[k].bm, v[k].bi);
            e = sb.pop_front();
            tests++;
            if ({hour, min, sec, mode, blink} !==
                {5'(e.h), 6'(e.mi), 6'(e.s), 2'(e.md), 1'(e.b)}) begin
                fails++;
                $display("FAIL %s: got %0d:%0d:%0d mode=%0d blink=%0d, want %0d:%0d:%0d mode=%0d blink=%0d",
                         e.nm, hour, min, sec, mode, blink, e.h, e.mi, e.s, e.md, e.b);
            end
        end
    endtask

    task automatic test_simultaneous();
        vec_t v[$];
        v.push_back(mk("sim_rst", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        v.push_back(mk("sim_mode_inc", 1, 0, 0, 1, 1, 0, 0, 0, 1, 1));
        v.push_back(mk("sim_to_min", 1, 0, 0, 1, 0, 0, 0, 0, 2, 1));
        v.push_back(mk("sim_to_sec", 1, 0, 0, 1, 0, 0, 0, 0, 3, 1));
        v.push_back(mk("sim_to_run", 1, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        v.push_back(mk("sim_ten", 10, 0, 1, 0, 0, 0, 0, 10, 0, 0));
        v.push_back(mk("sim_tick_mode", 1, 0, 1, 1, 0, 0, 0, 11, 1, 1));
        v.push_back(mk("sim_tick_inc", 1, 0, 1, 0, 1, 1, 0, 11, 1, 1));
        v.push_back(mk("sim_mi_hour", 1, 0, 0, 1, 1, 1, 0, 11, 2, 1));
        v.push_back(mk("sim_mi_min", 1, 0, 0, 1, 1, 1, 0, 11, 3, 1));
        v.push_back(mk("sim_mi_sec", 1, 0, 0, 1, 1, 1, 0, 11, 0, 0));
        for (int k = 0; k < v.size(); k++) begin
            sb.push_back(v[k]);
            repeat (v[k].n) drv(v[k].r, v[k].t, v[k].bm, v[k].bi);
            e = sb.pop_front();
            tests++;
            if ({hour, min, sec, mode, blink} !==
                {5'(e.h), 6'(e.mi), 6'(e.s), 2'(e.md), 1'(e.b)}) begin
                fails++;
                $display("FAIL %s: got %0d:%0d:%0d mode=%0d blink=%0d, want %0d:%0d:%0d mode=%0d blink=%0d",
                         e.nm, hour, min, sec, mode, blink, e.h, e.mi, e.s, e.md, e.b);
            end
        end
    endtask

    task automatic test_reset_mid_set();
        vec_t v[$];
        v.push_back(mk("rm_rst", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        v.push_back(mk("rm_sec56", 56, 0, 1, 0, 0, 0, 0, 56, 0, 0));
        v.push_back(mk("rm_set_hour", 1, 0, 0, 1, 0, 0, 0, 56, 1, 1));
        v.push_back(mk("rm_hour12", 12, 0, 0, 0, 1, 12, 0, 56, 1, 1));
        v.push_back(mk("rm_set_min", 1, 0, 0, 1, 0, 12, 0, 56, 2, 1));
        v.push_back(mk("rm_min34", 34, 0, 0, 0, 1, 12, 34, 56, 2, 1));
        v.push_back(mk("rm_reset", 1, 1, 1, 0, 1, 0, 0, 0, 0, 0));
        v.push_back(mk("rm_tick_after", 1, 0, 1, 0, 0, 0, 0, 1, 0, 0));
        for (int k = 0; k < v.size(); k++) begin
            sb.push_back(v[k]);
            repeat (v[k].n) drv(v[k].r, v[k].t, v[k].bm, v[k].bi);
            e = sb.pop_front();
            tests++;
            if ({hour, min, sec, mode, blink} !==
                {5'(e.h), 6'(e.mi), 6'(e.s), 2'(e.md), 1'(e.b)}) begin
                fails++;
                $display("FAIL %s: got %0d:%0d:%0d mode=%0d blink=%0d, want %0d:%0d:%0d mode=%0d blink=%0d",
                         e.nm, hour, min, sec, mode, blink, e.h, e.mi, e.s, e.md, e.b);
            end
        end
    endtask

    initial begin
        test_reset();
        test_run_count();
        test_day_wrap();
        test_set_wrap();
        test_blink_timeout();
        test_simultaneous();
        test_reset_mid_set();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/clock_time_controller.md
Name: clock_time_controller

Overview:
Time-keeping and time-setting controller for the clock chip. It consumes the single-cycle 1 Hz tick from the divider stage and two debounced single-cycle button pulses. It maintains the hh:mm:ss registers and sequences a RUN/SET mode FSM, including a set-mode blink indication and an auto-return timeout. Outputs feed the display/segment driver.

Parameters:
TIMEOUT_S, 30, number of 1 Hz ticks without a button press in any SET state before the FSM forces a return to RUN (range 1..63).

Ports:
clk  input  1  system clock, 100 MHz
rst  input  1  synchronous, active-high reset
tick_1hz  input  1  one-clk-wide pulse, once per second
btn_mode  input  1  one-clk-wide debounced pulse; advances the mode FSM
btn_inc  input  1  one-clk-wide debounced pulse; increments the selected field
hour  output  5  hours, 0..23
min  output  6  minutes, 0..59
sec  output  6  seconds, 0..59
mode  output  2  0=RUN, 1=SET_HOUR, 2=SET_MIN, 3=SET_SEC
blink  output  1  display blank phase for the field being set

Behaviour:
- All outputs are registered. A state or field change is visible on the clk edge after the causing input is sampled (1-cycle latency).
- Reset (rst=1 at posedge clk) sets hour=0, min=0, sec=0, mode=RUN, blink=0, idle_cnt=0. Reset overrides every other input, including mid-set and mid-carry.
- FSM transitions, on btn_mode only: RUN->SET_HOUR->SET_MIN->SET_SEC->RUN.
- RUN state:
  - On tick_1hz, sec increments.
  - sec 59->0 carries to min in the same cycle; min 59->0 carries to hour; hour 23->0 wraps.
  - 23:59:59 + tick gives 00:00:00 in a single cycle.
  - btn_inc is ignored.
- SET states:
  - Ticks do not advance time.
  - btn_inc in SET_HOUR: hour+1, 23->0, no carry.
  - btn_inc in SET_MIN: min+1, 59->0, no carry into hour.
  - btn_inc in SET_SEC: sec cleared to 0 (any value).
- blink:
  - Set to 1 on entry to any SET state.
  - Toggles on each tick_1hz while in a SET state.
  - Forced to 0 in RUN.
  - Does not toggle on the cycle a button is accepted.
- Timeout:
  - idle_cnt (6 bits) clears on entry to a SET state and on any btn_mode/btn_inc pulse.
  - Otherwise it increments on tick_1hz in SET states.
  - When idle_cnt reaches TIMEOUT_S on a tick: mode->RUN, blink=0, idle_cnt=0. That tick does not advance time.
- Simultaneous events:
  - btn_mode and btn_inc in the same cycle: btn_mode wins, btn_inc is discarded.
  - tick_1hz and btn_mode in RUN: time advances AND mode goes to SET_HOUR in the same cycle.
  - tick_1hz and btn_inc in a SET state: the increment applies; idle_cnt clears and does not count.
  - tick that reaches the timeout together with a button: the button wins (idle_cnt cleared, no timeout).
- Field values outside range are unreachable. The counters compare with ==MAX, not >=.

Decomposition:
- clock_pkg holds:
  - mode encodings MODE_RUN/SET_HOUR/SET_MIN/SET_SEC (2-bit localparams)
  - HOUR_MAX=23, MIN_MAX=59, SEC_MAX=59
- One natural sub-module, wrap_counter:
  - parameters WIDTH, MAX
  - inputs clk, rst, inc, clr
  - outputs value, carry (combinational: inc && value==MAX)
  - instantiated three times
  - the FSM drives inc/clr per mode; carry chaining is gated to RUN only.

Test Plan:
1. Reset, then 61 ticks in RUN -> hour=0, min=1, sec=1, mode=0, blink=0.
2. Preload 23:59:59 via SET (hour=23, min=59, 59 ticks after sec clear), then one tick in RUN -> 00:00:00 on the next clk.
3. btn_mode, then 24 btn_inc -> hour=0 (wrap), min unchanged. btn_mode, then 60 btn_inc -> min unchanged (wrap), no hour carry.
4. Enter SET_HOUR, apply 5 ticks -> blink sequence 1,0,1,0,1,0, time frozen. With TIMEOUT_S=30, after 30 idle ticks -> mode=RUN, blink=0.
5. btn_mode and btn_inc pulsed in the same cycle from RUN -> mode=SET_HOUR, hour unchanged. tick and btn_mode together at sec=10 in RUN -> sec=11, mode=SET_HOUR.
6. rst asserted for 1 cycle while in SET_MIN at 12:34:56 -> all outputs 0, mode=RUN. The next tick gives sec=1.
